// File: rtl/esc_phase_ctrl.sv
// Escalation phase sequencer.
// On an accepted trigger it walks N_PHASES timed phases, asserting one
// differential escalation line per phase, then parks in TERM until cleared.
// The escalation lines are encoded as {esc_p, esc_n}. Both halves come from one
// register bit per line: esc_p is the bit and esc_n is its complement.

package prim_esc_pkg;

   typedef struct packed {
      logic esc_p;
      logic esc_n;
   } esc_tx_t;

   parameter esc_tx_t ESC_TX_DEFAULT = '{esc_p: 1'b0, esc_n: 1'b1};

endpackage

module esc_phase_ctrl #(
   parameter int unsigned N_PHASES = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  trig_i,
   input  logic                                  clr_i,
   input  logic [N_PHASES*CNT_W-1:0]             phase_cyc_i,
   input  logic [N_PHASES-1:0]                   phase_en_i,
   output prim_esc_pkg::esc_tx_t [N_PHASES-1:0]  esc_tx_o,
   output logic [1:0]                            state_o,
   output logic [$clog2(N_PHASES):0]             phase_o,
   output logic [CNT_W-1:0]                      cnt_o,
   output logic                                  busy_o
);

   localparam int unsigned PW = $clog2(N_PHASES) + 1;
   localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PHASE = 2'd1,
      ST_TERM  = 2'd2
   } state_e;

   state_e                            r_state;
   logic [PW-1:0]                     r_phase;
   logic [CNT_W-1:0]                  r_cnt;
   logic                              r_busy;
   logic [N_PHASES-1:0][CNT_W-1:0]    r_cyc;
   logic [N_PHASES-1:0]               r_en;
   logic [N_PHASES-1:0]               r_line;

   logic [N_PHASES-1:0][CNT_W-1:0]    w_len_m1;
   logic [CNT_W-1:0]                  w_cur_len_m1;
   logic [N_PHASES-1:0]               w_next_line;
   logic                              w_last;
   logic                              w_done;

   // Terminal count per phase; a programmed length of 0 behaves like 1.
   generate
      for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_len
         assign w_len_m1[gi] = (r_cyc[gi] == '0) ? '0 : (r_cyc[gi] - CNT_W'(1));
      end
   endgenerate

   // Select the current phase's terminal count and the one-hot line pattern
   // for the following phase (gated by its shadowed enable).
   always_comb begin
      w_cur_len_m1 = '0;
      w_next_line  = '0;
      for (int k = 0; k < N_PHASES; k++) begin
         if (r_phase == PW'(k)) begin
            w_cur_len_m1 = w_len_m1[k];
         end
         if ((r_phase + PW'(1)) == PW'(k)) begin
            w_next_line[k] = r_en[k];
         end
      end
   end

   assign w_last = (r_phase == LAST_PHASE);
   assign w_done = (r_cnt == w_cur_len_m1);

   // Sequencer: clear has priority over everything but reset; config is
   // shadowed only at the accepting edge so later input changes are ignored.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_phase <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_cyc   <= '0;
         r_en    <= '0;
         r_line  <= '0;
      end else if (clr_i) begin
         r_state <= ST_IDLE;
         r_phase <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_line  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (trig_i) begin
                  r_state <= ST_PHASE;
                  r_phase <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_cyc   <= phase_cyc_i;
                  r_en    <= phase_en_i;
                  r_line  <= N_PHASES'(phase_en_i[0]);
               end
            end
            ST_PHASE: begin
               if (w_done) begin
                  r_cnt <= '0;
                  if (w_last) begin
                     r_state <= ST_TERM;
                     r_phase <= '0;
                     r_line  <= '0;
                  end else begin
                     r_phase <= r_phase + PW'(1);
                     r_line  <= w_next_line;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_TERM: begin
               r_phase <= '0;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
               r_line  <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_phase <= '0;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_line  <= '0;
            end
         endcase
      end
   end

   // Differential drive: one register bit and its complement per line.
   generate
      for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_tx
         assign esc_tx_o[gi].esc_p = r_line[gi];
         assign esc_tx_o[gi].esc_n = ~r_line[gi];
      end
   endgenerate

   assign state_o = r_state;
   assign phase_o = r_phase;
   assign cnt_o   = r_cnt;
   assign busy_o  = r_busy;

endmodule

// File: tb/tb_esc_phase_ctrl.sv
// Directed bench for esc_phase_ctrl: inputs are driven and outputs sampled on
// the falling clock edge, so each check sees the state after the last rising edge.

module tb_esc_phase_ctrl;

   localparam int N = 3;
   localparam int W = 16;

   logic                            clk = 1'b0;
   logic                            rst;
   logic                            trig;
   logic                            clr;
   logic [N*W-1:0]                  cyc;
   logic [N-1:0]                    en;
   prim_esc_pkg::esc_tx_t [N-1:0]   esc_tx;
   logic [1:0]                      state;
   logic [2:0]                      phase;
   logic [W-1:0]                    cnt;
   logic                            busy;

   int n_checks = 0;
   int n_fail   = 0;

   esc_phase_ctrl #(.N_PHASES(N), .CNT_W(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .trig_i      (trig),
      .clr_i       (clr),
      .phase_cyc_i (cyc),
      .phase_en_i  (en),
      .esc_tx_o    (esc_tx),
      .state_o     (state),
      .phase_o     (phase),
      .cnt_o       (cnt),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected packed line vector: element k = {esc_p, esc_n} = {b, ~b}.
   function automatic logic [2*N-1:0] enc(input logic [N-1:0] b);
      logic [2*N-1:0] r;
      for (int k = 0; k < N; k++) begin
         r[2*k+1] = b[k];
         r[2*k]   = ~b[k];
      end
      return r;
   endfunction

   task automatic chk_out(input string tag, input int st, input int ph, input int c,
                          input logic [N-1:0] lines, input logic bz);
      logic [2*N-1:0] v;
      v = esc_tx;
      chk({tag, ".state"}, 64'(state), 64'(st));
      chk({tag, ".phase"}, 64'(phase), 64'(ph));
      chk({tag, ".cnt"},   64'(cnt),   64'(c));
      chk({tag, ".tx"},    64'(v),     64'(enc(lines)));
      chk({tag, ".busy"},  64'(busy),  64'(bz));
   endtask

   // Trigger with the given config and walk the expected phase timeline.
   // mod_at >= 0 rewrites phase_cyc_i to all 9s at that cycle of the run.
   task automatic run_seq(input string tag, input logic [W-1:0] l0, input logic [W-1:0] l1,
                          input logic [W-1:0] l2, input logic [N-1:0] e, input int mod_at);
      logic [W-1:0] lens [N];
      logic [N-1:0] exp_l;
      int idx;
      int len;
      lens[0] = l0;
      lens[1] = l1;
      lens[2] = l2;
      $display("%s: trigger cyc={%0d,%0d,%0d} en=%b", tag, l0, l1, l2, e);
      cyc  = {l2, l1, l0};
      en   = e;
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      idx  = 0;
      for (int p = 0; p < N; p++) begin
         len = (lens[p] == 0) ? 1 : int'(lens[p]);
         for (int c = 0; c < len; c++) begin
            if (idx == mod_at) cyc = {3{16'd9}};
            exp_l    = '0;
            exp_l[p] = e[p];
            chk_out($sformatf("%s.p%0d.c%0d", tag, p, c), 1, p, c, exp_l, 1'b1);
            idx++;
            @(negedge clk);
         end
      end
      chk_out({tag, ".term"}, 2, 0, 0, 3'b000, 1'b1);
   endtask

   task automatic do_clear();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst  = 1'b1;
      trig = 1'b0;
      clr  = 1'b0;
      cyc  = '0;
      en   = '0;
      repeat (2) @(negedge clk);
      chk_out("reset", 0, 0, 0, 3'b000, 1'b0);
      rst = 1'b0;

      // 1: idle with trig low, lines at default and never equal halves
      $display("t1: idle for 10 cycles");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_out("t1.idle", 0, 0, 0, 3'b000, 1'b0);
         for (int k = 0; k < N; k++)
            chk("t1.diff", 64'(esc_tx[k].esc_p ^ esc_tx[k].esc_n), 64'd1);
      end

      // 2: basic three-phase run
      run_seq("t2", 16'd4, 16'd2, 16'd3, 3'b111, -1);
      @(negedge clk);
      chk_out("t2.term2", 2, 0, 0, 3'b000, 1'b1);
      do_clear();
      chk_out("t2.idle", 0, 0, 0, 3'b000, 1'b0);

      // 3: zero length treated as one, disabled middle phase
      run_seq("t3", 16'd0, 16'd1, 16'd5, 3'b101, -1);
      do_clear();

      // 4: config change after trigger has no effect
      run_seq("t4", 16'd4, 16'd2, 16'd3, 3'b111, 2);
      do_clear();

      // 5: clear during phase1 with trig held high, then re-entry
      $display("t5: clear mid phase1 with trig held");
      cyc  = {16'd2, 16'd5, 16'd2};
      en   = 3'b111;
      trig = 1'b1;
      @(negedge clk);
      chk_out("t5.p0c0", 1, 0, 0, 3'b001, 1'b1);
      @(negedge clk);
      chk_out("t5.p0c1", 1, 0, 1, 3'b001, 1'b1);
      @(negedge clk);
      chk_out("t5.p1c0", 1, 1, 0, 3'b010, 1'b1);
      @(negedge clk);
      chk_out("t5.p1c1", 1, 1, 1, 3'b010, 1'b1);
      @(negedge clk);
      chk_out("t5.p1c2", 1, 1, 2, 3'b010, 1'b1);
      clr = 1'b1;
      @(negedge clk);
      chk_out("t5.clr", 0, 0, 0, 3'b000, 1'b0);
      clr = 1'b0;
      @(negedge clk);
      chk_out("t5.retrig", 1, 0, 0, 3'b001, 1'b1);
      trig = 1'b0;
      do_clear();

      // 6: TERM ignores trig; clear together with trig holds IDLE
      run_seq("t6", 16'd1, 16'd1, 16'd1, 3'b111, -1);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      chk_out("t6.term_trig", 2, 0, 0, 3'b000, 1'b1);
      @(negedge clk);
      chk_out("t6.term_hold", 2, 0, 0, 3'b000, 1'b1);
      clr  = 1'b1;
      trig = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_out("t6.clr_trig", 0, 0, 0, 3'b000, 1'b0);
      end
      clr  = 1'b0;
      trig = 1'b0;
      @(negedge clk);
      chk_out("t6.idle", 0, 0, 0, 3'b000, 1'b0);

      // 7: reset in the middle of a sequence
      $display("t7: reset mid sequence");
      cyc  = {16'd4, 16'd4, 16'd4};
      en   = 3'b111;
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      @(negedge clk);
      chk_out("t7.run", 1, 0, 1, 3'b001, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_out("t7.rst", 0, 0, 0, 3'b000, 1'b0);
      @(negedge clk);
      chk_out("t7.idle", 0, 0, 0, 3'b000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/esc_phase_ctrl.md
Name: esc_phase_ctrl

Overview:
Escalation phase sequencer that drives the packed array of differential escalation lines (prim_esc_pkg::esc_tx_t) consumed by escalation receivers such as the NMI generator. On a trigger, it steps through N_PHASES timed phases. Phase k asserts escalation line k for a programmed number of cycles. After the last phase the block parks in a terminal state until it is cleared. It is the single owner of the esc_tx lines; nothing else may drive them.

Parameters:
N_PHASES, 3, number of escalation phases and width of esc_tx_o (int unsigned, ≥1)
CNT_W, 16, width of the per-phase cycle counter and of each phase length

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
trig_i  input  1  escalation request; level, sampled only in IDLE
clr_i  input  1  clear; returns the block to IDLE from any state
phase_cyc_i  input  N_PHASES*CNT_W  per-phase duration in cycles; [k] is phase k
phase_en_i  input  N_PHASES  per-phase output enable
esc_tx_o  output  esc_tx_t [N_PHASES-1:0]  differential escalation lines
state_o  output  2  0=IDLE, 1=PHASE, 2=TERM
phase_o  output  $clog2(N_PHASES)+1  current phase index (0 outside PHASE)
cnt_o  output  CNT_W  cycles elapsed in the current phase (0 outside PHASE)
busy_o  output  1  high in PHASE or TERM

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (rst_i, sampled on the rising edge of clk_i).
- Reset values:
  - every esc_tx_o[k] = ESC_TX_DEFAULT (esc_p=0, esc_n=1)
  - state_o=IDLE, phase_o=0, cnt_o=0, busy_o=0
  - shadow config registers = 0
- All outputs are registered; there is no combinational path from inputs to outputs.
- Differential encoding:
  - Asserted line: esc_p=1, esc_n=0. Idle line: ESC_TX_DEFAULT.
  - esc_p and esc_n come from one register bit and its complement, so they are never equal in any cycle, including reset.
- Config shadowing:
  - phase_cyc_i and phase_en_i are captured into shadow registers in the cycle trig_i is accepted.
  - Input changes during PHASE or TERM have no effect.
  - A captured length of 0 is treated as 1.
- FSM:
  - IDLE:
    - trig_i=1 and clr_i=0 -> PHASE with phase=0, cnt=0, config captured.
    - Otherwise stay in IDLE.
  - PHASE(k):
    - esc_tx_o[k] is asserted iff the shadow enable[k]=1. All other lines are at default.
    - cnt increments by 1 every cycle.
    - When cnt == len_k-1 (len_k = max(shadow_cyc[k],1)) and k < N_PHASES-1: next state is PHASE(k+1) with cnt=0.
    - When cnt == len_k-1 and k == N_PHASES-1: next state is TERM.
    - The counter never wraps, because the terminal compare happens first.
  - TERM:
    - All lines are at default; busy_o=1.
    - Stay in TERM until clr_i; trig_i is ignored.
- Latency:
  - trig_i sampled high at edge t gives state_o=PHASE and esc_tx_o[0] asserted (if enabled) from t+1.
  - Phase k occupies exactly len_k consecutive cycles.
  - Exactly one line is asserted at a time. Phase k+1 asserts in the cycle immediately after phase k deasserts, with no gap and no overlap.
- clr_i:
  - Highest priority after rst_i, in any state.
  - Next cycle: state IDLE, all lines default, cnt=0, phase=0.
  - clr_i and trig_i high together in IDLE: stay in IDLE.
  - Re-triggering needs trig_i high in a cycle with clr_i=0 while in IDLE; a level still held after the clear retriggers one cycle later.
- rst_i mid-sequence: same outcome as clr_i, and the shadow config is also cleared.
- Illegal or unused state encoding (3): recover to IDLE next cycle with all lines at default.

Test Plan:
1. Reset, then hold trig_i=0 for 10 cycles -> all esc_tx_o = {p=0,n=1}, state_o=0, busy_o=0, and esc_p != esc_n in every cycle.
2. phase_cyc={4,2,3}, phase_en=3'b111, trig_i pulse at edge t:
   - line0 asserted for t+1..t+4, line1 for t+5..t+6, line2 for t+7..t+9
   - TERM from t+10, cnt_o walks 0..3, 0..1, 0..2
3. phase_cyc={0,1,5}, phase_en=3'b101:
   - phase0 lasts 1 cycle asserted, phase1 lasts 1 cycle with all lines default, phase2 lasts 5 cycles asserted
   - TERM after 7 cycles total
4. Change phase_cyc_i to {9,9,9} two cycles after the trigger of scenario 2 -> the timing is identical to scenario 2 (shadowing holds).
5. clr_i at cycle 3 of phase1 -> next cycle IDLE, all lines default. With trig_i held high through the clear, PHASE0 re-enters one cycle after the clear deasserts.
6. In TERM, pulse trig_i -> no change; then clr_i=1 together with trig_i=1 -> IDLE, stays in IDLE while clr_i=1.
